instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
Fetch sequencer for the multicycle processor.
- Owns the program counter and drives the address of the asynchronous, fixed-delay instruction memory.
- Waits a parameterised number of cycles for read data to settle, then latches it into the instruction register (IR).
- Presents the instruction to the main control unit with a valid/ack handshake.
- Handles PC redirects (branch/jump) with abort of any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset.
WAIT_CYCLES, 2, extra cycles the address is held before IR capture; covers the memory's 1000 ps delay; legal range 0..15.
CNT_W, 16, width of the retired-fetch counter.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
fetch_req  in  1  control unit requests the instruction at the current PC.
pc_load  in  1  redirect strobe; highest priority.
pc_target  in  32  redirect destination.
instr_ack  in  1  control unit has consumed the IR.
imem_rdata  in  32  instruction-memory read data.
imem_addr  out  32  instruction-memory address; equals pc.
instr  out  32  IR.
pc  out  32  address of the instruction being fetched or held.
pc_plus4  out  32  pc + 4, modulo 2^32, combinational.
instr_valid  out  1  IR holds a valid instruction.
busy  out  1  high in WAIT state.
fetch_count  out  CNT_W  number of acknowledged instructions; wraps.

Behaviour:
- Reset, synchronous, same edge: pc=RESET_PC, instr=0, instr_valid=0, busy=0, fetch_count=0, state=IDLE, wait counter=0.
- States:
  - IDLE: fetch_req=1 -> load counter=WAIT_CYCLES, go WAIT.
  - WAIT: busy=1. If counter≠0, decrement. If counter=0, instr<=imem_rdata, instr_valid<=1, go HOLD.
  - HOLD: instr_valid=1; IR and pc are stable.
    - instr_ack=1 and fetch_req=0 -> pc<=pc+4, instr_valid<=0, go IDLE.
    - instr_ack=1 and fetch_req=1 -> pc<=pc+4, reload counter, go WAIT. This is back-to-back fetch.
    - Every ack increments fetch_count.
- Latency: fetch_req sampled high at edge N -> instr_valid high after edge N+WAIT_CYCLES+1. With WAIT_CYCLES=0, capture occurs on the next edge.
- imem_addr changes only on pc update, never during WAIT.
- instr_ack outside HOLD: ignored. fetch_req outside IDLE/HOLD: ignored.
- pc_load, any state: pc<=pc_target, instr_valid<=0, state<=IDLE, counter cleared. It overrides a same-cycle instr_ack (no increment, no fetch_count change) and a same-cycle fetch_req. A fetch in WAIT is aborted and its data discarded.
- Reset overrides pc_load.
- pc wraps 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
- instr holds its last value when instr_valid=0. The IR is not cleared except by reset.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined:
  - Adds output align_err (1 bit), reset to 0.
  - pc_load with pc_target[1:0]≠0 sets align_err; it is sticky until reset.
  - pc is loaded with pc_target & ~32'h3.
- Undefined:
  - No align_err port.
  - pc_target is loaded verbatim; the memory's word indexing ignores the low bits.

Decomposition:
- Shared package fetch_pkg contains:
  - the state enumeration IDLE/WAIT/HOLD;
  - the default reset PC constant;
  - the word stride constant 4;
  - the maximum wait-cycle constant 15.
- One sub-module, fetch_wait_timer:
  - 4-bit loadable down-counter;
  - inputs load and load value;
  - output done when count=0.

Test Plan:
- Reset, then fetch_req pulse at cycle 1, WAIT_CYCLES=2, imem_rdata=32'h2002_0005 -> instr_valid rises after edge 4; instr=32'h2002_0005, pc=0, busy high for cycles 2-4.
- Hold fetch_req and instr_ack high continuously -> pc sequence 0,4,8,12; fetch_count 1,2,3; imem_addr stable throughout each WAIT.
- pc_load=1 with pc_target=32'h40 in the middle of WAIT -> instr_valid stays 0, state IDLE, pc=32'h40; the next fetch returns the word at 0x40.
- pc_load with instr_ack in the same HOLD cycle, pc_target=32'h100 -> pc=32'h100, fetch_count unchanged.
- pc_load to 32'hFFFF_FFFC, fetch, ack -> pc=0. Set CNT_W=2; after 4 acks fetch_count=0.
- FETCH_ALIGN_CHECK_EN defined, pc_target=32'h0000_0046 -> pc=32'h44, align_err=1 and held until reset; reset -> align_err=0, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
//   fetch_state_e   : sequencer state (IDLE / WAIT / HOLD)
//   DefaultResetPc  : PC value loaded by reset unless overridden
//   WordStride      : byte distance between consecutive instructions
//   MaxWaitCycles   : largest settle delay the wait timer can count
//   WaitCntW        : width of the wait timer
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StHold = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;
  localparam logic [31:0] WordStride     = 32'd4;
  localparam int unsigned MaxWaitCycles  = 15;
  localparam int unsigned WaitCntW       = 4;

endpackage

// File: rtl/fetch_wait_timer.sv
// Loadable down-counter that times the instruction-memory settle delay.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset (count <= 0)
//   clear    in   abort: count <= 0 (wins over load)
//   load     in   count <= load_val
//   load_val in   reload value (0..15)
//   en       in   decrement while nonzero
//   done     out  count == 0
module fetch_wait_timer
  import fetch_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                load,
  input  logic [WaitCntW-1:0] load_val,
  input  logic                en,
  output logic                done
);

  logic [WaitCntW-1:0] count_q;

  assign done = (count_q == '0);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && !done) begin
      count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer for the multicycle processor. Owns the PC, holds the
// instruction-memory address steady for WAIT_CYCLES extra cycles, captures the
// read data into the IR and offers it to the control unit via valid/ack.
// A redirect (pc_load) aborts any in-flight fetch and returns to IDLE.
// Optional build macro: FETCH_ALIGN_CHECK_EN adds a sticky align_err output and
// forces redirect targets to word alignment.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   fetch_req           request instruction at current pc
//   pc_load, pc_target  redirect strobe (highest priority) and destination
//   instr_ack           control unit consumed the IR
//   imem_rdata          instruction-memory read data
//   imem_addr           instruction-memory address (= pc)
//   instr, instr_valid  IR and its valid flag
//   pc, pc_plus4        current pc and pc + 4
//   busy                high in WAIT
//   fetch_count         acknowledged-instruction count (wraps)
//   align_err           sticky misaligned-redirect flag (optional)
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DefaultResetPc,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_req,
  input  logic             pc_load,
  input  logic [31:0]      pc_target,
  input  logic             instr_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      imem_addr,
  output logic [31:0]      instr,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             instr_valid,
  output logic             busy,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic             align_err,
`endif
  output logic [CNT_W-1:0] fetch_count
);

  // Out-of-range settings saturate at what the 4-bit timer can hold.
  localparam logic [WaitCntW-1:0] WaitLoad = (WAIT_CYCLES > MaxWaitCycles) ?
      WaitCntW'(MaxWaitCycles) : WaitCntW'(WAIT_CYCLES);

  fetch_state_e state;
  logic         timer_done;
  logic         timer_load;
  logic [31:0]  target_eff;

`ifdef FETCH_ALIGN_CHECK_EN
  assign target_eff = {pc_target[31:2], 2'b00};
`else
  assign target_eff = pc_target;
`endif

  assign imem_addr = pc;
  assign pc_plus4  = pc + WordStride;
  assign busy      = (state == StWait);

  // Start a fetch from IDLE, or back-to-back from HOLD on an ack.
  assign timer_load = !pc_load && fetch_req &&
                      ((state == StIdle) || ((state == StHold) && instr_ack));

  fetch_wait_timer u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (pc_load),
    .load     (timer_load),
    .load_val (WaitLoad),
    .en       (state == StWait),
    .done     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_count <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      align_err   <= 1'b0;
`endif
    end else if (pc_load) begin
      // Redirect: drops any pending fetch and swallows a same-cycle ack.
      pc          <= target_eff;
      instr_valid <= 1'b0;
      state       <= StIdle;
`ifdef FETCH_ALIGN_CHECK_EN
      if (pc_target[1:0] != 2'b00) align_err <= 1'b1;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (fetch_req) state <= StWait;
        end
        StWait: begin
          if (timer_done) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= StHold;
          end
        end
        StHold: begin
          if (instr_ack) begin
            pc          <= pc + WordStride;
            instr_valid <= 1'b0;
            fetch_count <= fetch_count + CNT_W'(1);
            state       <= fetch_req ? StWait : StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: a table of per-cycle vectors plus a few
// hand-written sequences. A second instance with CNT_W=2 shares the stimulus
// to exercise counter wrap.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        instr_ack;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr, instr, pc, pc_plus4;
  logic        instr_valid, busy;
  logic [15:0] fetch_count;
  logic [31:0] imem_addr2, instr2, pc2, pc_plus4_2;
  logic        instr_valid2, busy2;
  logic [1:0]  fetch_count2;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        align_err, align_err2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Memory model: each address returns a distinct recognisable word.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h2002_0005 ^ {a[15:0], 16'h0000};
  endfunction

  assign imem_rdata = word_at(imem_addr);

  instr_fetch_ctrl #(.RESET_PC(32'h0), .WAIT_CYCLES(2), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .instr_ack   (instr_ack),
    .imem_rdata  (imem_rdata),
    .imem_addr   (imem_addr),
    .instr       (instr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .busy        (busy),
`ifdef FETCH_ALIGN_CHECK_EN
    .align_err   (align_err),
`endif
    .fetch_count (fetch_count)
  );

  instr_fetch_ctrl #(.RESET_PC(32'h0), .WAIT_CYCLES(2), .CNT_W(2)) dut_w2 (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .instr_ack   (instr_ack),
    .imem_rdata  (imem_rdata),
    .imem_addr   (imem_addr2),
    .instr       (instr2),
    .pc          (pc2),
    .pc_plus4    (pc_plus4_2),
    .instr_valid (instr_valid2),
    .busy        (busy2),
`ifdef FETCH_ALIGN_CHECK_EN
    .align_err   (align_err2),
`endif
    .fetch_count (fetch_count2)
  );

  typedef struct {
    logic        req;
    logic        ack;
    logic        ld;
    logic [31:0] tgt;
    logic        e_valid;
    logic        e_busy;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic ack, input logic ld, input logic [31:0] tgt);
    fetch_req = req;
    instr_ack = ack;
    pc_load   = ld;
    pc_target = tgt;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] w0, w4, w8, w40, wtop;
    int lat;
    w0   = word_at(32'h0000_0000);
    w4   = word_at(32'h0000_0004);
    w8   = word_at(32'h0000_0008);
    w40  = word_at(32'h0000_0040);
    wtop = word_at(32'hFFFF_FFFC);

    // req ack ld tgt | valid busy pc instr count
    vecs.push_back('{1, 0, 0, 32'h0,  0, 1, 32'h0,  32'h0, 16'd0}); // start fetch @0
    vecs.push_back('{0, 0, 0, 32'h0,  0, 1, 32'h0,  32'h0, 16'd0});
    vecs.push_back('{0, 0, 0, 32'h0,  0, 1, 32'h0,  32'h0, 16'd0});
    vecs.push_back('{0, 0, 0, 32'h0,  1, 0, 32'h0,  w0,    16'd0}); // capture
    vecs.push_back('{0, 0, 0, 32'h0,  1, 0, 32'h0,  w0,    16'd0}); // hold, no ack
    vecs.push_back('{1, 1, 0, 32'h0,  0, 1, 32'h4,  w0,    16'd1}); // back-to-back
    vecs.push_back('{1, 1, 0, 32'h0,  0, 1, 32'h4,  w0,    16'd1}); // ack in WAIT ignored
    vecs.push_back('{1, 1, 0, 32'h0,  0, 1, 32'h4,  w0,    16'd1});
    vecs.push_back('{1, 0, 0, 32'h0,  1, 0, 32'h4,  w4,    16'd1});
    vecs.push_back('{1, 1, 0, 32'h0,  0, 1, 32'h8,  w4,    16'd2});
    vecs.push_back('{1, 1, 0, 32'h0,  0, 1, 32'h8,  w4,    16'd2});
    vecs.push_back('{1, 1, 0, 32'h0,  0, 1, 32'h8,  w4,    16'd2});
    vecs.push_back('{1, 0, 0, 32'h0,  1, 0, 32'h8,  w8,    16'd2});
    vecs.push_back('{1, 1, 0, 32'h0,  0, 1, 32'hC,  w8,    16'd3});
    vecs.push_back('{1, 0, 1, 32'h40, 0, 0, 32'h40, w8,    16'd3}); // abort mid-WAIT
    vecs.push_back('{1, 0, 0, 32'h0,  0, 1, 32'h40, w8,    16'd3});
    vecs.push_back('{0, 0, 0, 32'h0,  0, 1, 32'h40, w8,    16'd3});
    vecs.push_back('{0, 0, 0, 32'h0,  0, 1, 32'h40, w8,    16'd3});
    vecs.push_back('{0, 0, 0, 32'h0,  1, 0, 32'h40, w40,   16'd3});
    vecs.push_back('{1, 1, 1, 32'h100, 0, 0, 32'h100, w40, 16'd3}); // redirect beats ack
    vecs.push_back('{0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, w40, 16'd3});
    vecs.push_back('{1, 0, 0, 32'h0,  0, 1, 32'hFFFF_FFFC, w40, 16'd3});
    vecs.push_back('{0, 0, 0, 32'h0,  0, 1, 32'hFFFF_FFFC, w40, 16'd3});
    vecs.push_back('{0, 0, 0, 32'h0,  0, 1, 32'hFFFF_FFFC, w40, 16'd3});
    vecs.push_back('{0, 0, 0, 32'h0,  1, 0, 32'hFFFF_FFFC, wtop, 16'd3});
    vecs.push_back('{0, 1, 0, 32'h0,  0, 0, 32'h0,  wtop,  16'd4}); // pc wraps to 0

    // Reset state.
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    tick();
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_count", {16'b0, fetch_count}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].req, vecs[i].ack, vecs[i].ld, vecs[i].tgt);
      tick();
      check($sformatf("v%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
      check($sformatf("v%0d_busy", i), {31'b0, busy}, {31'b0, vecs[i].e_busy});
      check($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_pc);
      check($sformatf("v%0d_pc4", i), pc_plus4, vecs[i].e_pc + 32'd4);
      check($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
      check($sformatf("v%0d_count", i), {16'b0, fetch_count}, {16'b0, vecs[i].e_cnt});
      check($sformatf("v%0d_count_w2", i), {30'b0, fetch_count2}, {30'b0, vecs[i].e_cnt[1:0]});
    end

    // Latency: single-cycle request pulse, valid after WAIT_CYCLES+1 edges.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    lat = 0;
    while (!instr_valid && lat < 20) begin
      check($sformatf("lat_busy%0d", lat), {31'b0, busy}, 32'h1);
      tick();
      lat++;
    end
    check("latency", lat, 3);
    check("lat_instr", instr, w0);
    check("lat_busy_off", {31'b0, busy}, 32'h0);

    // Reset wins over a same-cycle redirect.
    drive(1'b0, 1'b0, 1'b1, 32'h200);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("rst_over_ld_pc", pc, 32'h0);
    check("rst_over_ld_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_over_ld_instr", instr, 32'h0);

    // Misaligned redirect target.
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0046);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("align_pc", pc, 32'h44);
    check("align_err_set", {31'b0, align_err}, 32'h1);
    drive(1'b0, 1'b0, 1'b1, 32'h80);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("align_err_sticky", {31'b0, align_err}, 32'h1);
    check("align_pc2", pc, 32'h80);
    do_reset();
    check("align_err_rst", {31'b0, align_err}, 32'h0);
    check("align_rst_pc", pc, 32'h0);
`else
    check("verbatim_pc", pc, 32'h46);
    check("verbatim_addr", imem_addr, 32'h46);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
